// File: rtl/uart_coe_loader.sv
// Receives a big-endian 32-bit program image over 8N1 UART and writes it to memory from word 0.
// Optional byte echo on the TX line is enabled by defining UART_COE_LOADER_ECHO_EN.
module uart_coe_loader #(
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned BAUD         = 128000,
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned WORD_COUNT   = 16384,
  parameter int unsigned TIMEOUT_BITS = 1000
) (
  input  logic                  iFpgaClk,
  input  logic                  iFpgaRstN,
  input  logic                  iStartReceiveCoe,
  input  logic                  iFpgaUartFromPc,
  output logic                  oFpgaUartToPc,
  output logic                  oLoading,
  output logic                  oDone,
  output logic                  oFrameErr,
  output logic                  oWrEn,
  output logic [ADDR_WIDTH-1:0] oWrAddr,
  output logic [31:0]           oWrData
);

  localparam int unsigned BIT_DIV  = CLK_HZ / BAUD;
  localparam int unsigned HALF_DIV = BIT_DIV / 2;
  localparam int unsigned TOUT_CYC = TIMEOUT_BITS * BIT_DIV;
  localparam int unsigned DIV_W    = $clog2(BIT_DIV + 1);
  localparam int unsigned TOUT_W   = $clog2(TOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} top_state_t;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_t;

  top_state_t            state;
  rx_state_t             rx_st;
  logic [1:0]            start_s;
  logic                  start_prev;
  logic [1:0]            rx_s;
  logic                  start_edge;
  logic                  rx_sync;
  logic [DIV_W-1:0]      rx_cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            rx_byte;
  logic [31:0]           word;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [TOUT_W-1:0]     tout_cnt;
  logic                  got_byte;
  logic                  wr_req;
  logic                  last_wr;
`ifdef UART_COE_LOADER_ECHO_EN
  logic                  byte_ok;
`endif

  assign start_edge = start_s[1] & ~start_prev;
  assign rx_sync    = rx_s[1];
  assign oLoading   = (state == StLoad);
  assign oDone      = (state == StDone);

  always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
    if (!iFpgaRstN) begin
      start_s    <= 2'b00;
      start_prev <= 1'b0;
      rx_s       <= 2'b11;
    end else begin
      start_s    <= {start_s[0], iStartReceiveCoe};
      start_prev <= start_s[1];
      rx_s       <= {rx_s[0], iFpgaUartFromPc};
    end
  end

  always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
    if (!iFpgaRstN) begin
      state     <= StIdle;
      rx_st     <= RxIdle;
      rx_cnt    <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      word      <= '0;
      byte_cnt  <= '0;
      word_idx  <= '0;
      tout_cnt  <= '0;
      got_byte  <= 1'b0;
      wr_req    <= 1'b0;
      last_wr   <= 1'b0;
      oFrameErr <= 1'b0;
      oWrEn     <= 1'b0;
      oWrAddr   <= '0;
      oWrData   <= '0;
`ifdef UART_COE_LOADER_ECHO_EN
      byte_ok   <= 1'b0;
`endif
    end else begin
      oWrEn <= 1'b0;
`ifdef UART_COE_LOADER_ECHO_EN
      byte_ok <= 1'b0;
`endif
      if (state != StLoad) begin
        rx_st <= RxIdle;
        if (start_edge) begin
          state     <= StLoad;
          word_idx  <= '0;
          byte_cnt  <= '0;
          tout_cnt  <= '0;
          got_byte  <= 1'b0;
          wr_req    <= 1'b0;
          last_wr   <= 1'b0;
          oFrameErr <= 1'b0;
        end
      end else begin
        if (wr_req) begin
          oWrEn    <= 1'b1;
          oWrAddr  <= word_idx;
          oWrData  <= word;
          word_idx <= word_idx + 1'b1;
          wr_req   <= 1'b0;
          last_wr  <= (word_idx == ADDR_WIDTH'(WORD_COUNT - 1));
        end
        // A pending write always drains before a timeout is allowed to end the load.
        if (last_wr) begin
          state <= StDone;
        end else if (tout_cnt == TOUT_W'(TOUT_CYC) && !wr_req) begin
          state <= StDone;
        end

        unique case (rx_st)
          RxIdle: begin
            if (!rx_sync) begin
              rx_st    <= RxStart;
              rx_cnt   <= '0;
              tout_cnt <= '0;
            end else if (got_byte && tout_cnt != TOUT_W'(TOUT_CYC)) begin
              tout_cnt <= tout_cnt + 1'b1;
            end
          end
          RxStart: begin
            if (rx_cnt == DIV_W'(HALF_DIV - 1)) begin
              rx_cnt  <= '0;
              bit_idx <= '0;
              rx_st   <= rx_sync ? RxIdle : RxData;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RxData: begin
            if (rx_cnt == DIV_W'(BIT_DIV - 1)) begin
              rx_cnt  <= '0;
              rx_byte <= {rx_sync, rx_byte[7:1]};
              if (bit_idx == 3'd7) begin
                rx_st <= RxStop;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          RxStop: begin
            if (rx_cnt == DIV_W'(BIT_DIV - 1)) begin
              rx_cnt <= '0;
              rx_st  <= RxIdle;
              if (rx_sync) begin
                word     <= {word[23:0], rx_byte};
                got_byte <= 1'b1;
`ifdef UART_COE_LOADER_ECHO_EN
                byte_ok  <= 1'b1;
`endif
                if (byte_cnt == 2'd3) begin
                  byte_cnt <= '0;
                  wr_req   <= 1'b1;
                end else begin
                  byte_cnt <= byte_cnt + 1'b1;
                end
              end else begin
                oFrameErr <= 1'b1;
              end
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end
          default: rx_st <= RxIdle;
        endcase
      end
    end
  end

`ifdef UART_COE_LOADER_ECHO_EN
  logic             tx_line;
  logic             tx_busy;
  logic             tx_free;
  logic [8:0]       tx_shift;
  logic [DIV_W-1:0] tx_cnt;
  logic [3:0]       tx_left;

  // The final stop-bit cycle counts as free so back-to-back bytes are not dropped.
  assign tx_free = !tx_busy || (tx_cnt == '0 && tx_left == '0);

  always_ff @(posedge iFpgaClk or negedge iFpgaRstN) begin
    if (!iFpgaRstN) begin
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_left  <= '0;
    end else if (state != StLoad) begin
      tx_line <= 1'b1;
      tx_busy <= 1'b0;
    end else if (byte_ok && tx_free) begin
      tx_line  <= 1'b0;
      tx_shift <= {1'b1, rx_byte};
      tx_cnt   <= DIV_W'(BIT_DIV - 1);
      tx_left  <= 4'd9;
      tx_busy  <= 1'b1;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_left == '0) begin
        tx_busy <= 1'b0;
      end else begin
        tx_line  <= tx_shift[0];
        tx_shift <= {1'b0, tx_shift[8:1]};
        tx_cnt   <= DIV_W'(BIT_DIV - 1);
        tx_left  <= tx_left - 1'b1;
      end
    end
  end

  assign oFpgaUartToPc = tx_line;
`else
  assign oFpgaUartToPc = 1'b1;
`endif

endmodule

// File: tb/tb_uart_coe_loader.sv
// Randomised bench for uart_coe_loader with a byte/word-level reference model of the loader.
module tb_uart_coe_loader;

  localparam int unsigned WC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rx = 1'b1;
  logic        tx;
  logic        loading, done, frame_err, wr_en;
  logic [13:0] wr_addr;
  logic [31:0] wr_data;

  uart_coe_loader #(
    .CLK_HZ(1600), .BAUD(100), .ADDR_WIDTH(14), .WORD_COUNT(WC), .TIMEOUT_BITS(20)
  ) dut (
    .iFpgaClk(clk), .iFpgaRstN(rst_n), .iStartReceiveCoe(start), .iFpgaUartFromPc(rx),
    .oFpgaUartToPc(tx), .oLoading(loading), .oDone(done), .oFrameErr(frame_err),
    .oWrEn(wr_en), .oWrAddr(wr_addr), .oWrData(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          m_load = 0, m_got = 0, m_fe = 0;
  int          m_words = 0, m_bytes = 0;
  logic [31:0] m_word = '0;
  logic [13:0] m_last_a = '0;
  logic [31:0] m_last_d = '0;
  bit          exp_done_next = 0;
  bit          prev_wren = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the write port and line invariants against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_done_next) begin
        chk("done_after_last_wr", {62'b0, done, loading}, 64'd2);
        exp_done_next = 0;
      end
      if (wr_en) begin
        wr_t e;
        chk("wr_single", prev_wren, 0);
        chk("wr_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", wr_addr, e.a);
          chk("wr_data", wr_data, e.d);
          m_last_a = e.a;
          m_last_d = e.d;
          if (e.a == 14'(WC - 1)) exp_done_next = 1;
        end
        e.a = wr_addr;
        e.d = wr_data;
        obs_q.push_back(e);
      end else begin
        chk("wr_hold_addr", wr_addr, m_last_a);
        chk("wr_hold_data", wr_data, m_last_d);
      end
`ifndef UART_COE_LOADER_ECHO_EN
      chk("tx_idle_high", tx, 1);
`endif
      chk("load_done_excl", loading & done, 0);
    end
    prev_wren = wr_en;
  end

  task automatic start_pulse();
    if (!m_load) begin
      m_load = 1; m_got = 0; m_fe = 0; m_words = 0; m_bytes = 0;
    end
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("loading_after_start", loading, 1);
    chk("not_done_after_start", done, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    wr_t e;
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (16) @(negedge clk);
    end
    if (good) begin
      if (m_load) begin
        m_word = {m_word[23:0], b};
        m_got = 1;
        m_bytes++;
        if (m_bytes == 4) begin
          e.a = 14'(m_words);
          e.d = m_word;
          exp_q.push_back(e);
          m_words++;
          m_bytes = 0;
          if (m_words == WC) m_load = 0;
        end
      end
      rx = 1'b1;
      repeat (16) @(negedge clk);
    end else begin
      if (m_load) m_fe = 1;
      rx = 1'b0;
      repeat (12) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
    end
    chk("frame_err", frame_err, m_fe);
  endtask

  task automatic glitch();
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_end();
    int n = 0;
    if (m_load && m_got) begin
      while (!done && n < 700) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_done", done, 1);
      m_load = 0;
      m_bytes = 0;
    end
    chk("done_state", {62'b0, done, loading}, 64'd2);
    chk("no_pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit1[8];
    int n;
    lit1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    repeat (3) @(negedge clk);
    chk("rst_loading", loading, 0);
    chk("rst_done", done, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_wren", wr_en, 0);
    chk("rst_tx", tx, 1);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: two literal words, then timeout.
    start_pulse();
    for (int i = 0; i < 8; i++) send_byte(lit1[i], 1);
    wait_end();
    chk("t1_nwr", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t1_w0", {obs_q[0].a, obs_q[0].d}, {14'd0, 32'h12345678});
      chk("t1_w1", {obs_q[1].a, obs_q[1].d}, {14'd1, 32'h9ABCDEF0});
    end
    obs_q.delete();

    // 2: word-count end, extra byte ignored.
    start_pulse();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'($urandom), 1);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    chk("t2_nwr", obs_q.size(), 4);
    chk("t2_done", done, 1);
    obs_q.delete();

    // 3: partial word discarded, timeout measured, restart at address 0.
    start_pulse();
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("t3_not_early", n >= 306, 1);
    chk("t3_not_late", n <= 326, 1);
    m_load = 0;
    m_bytes = 0;
    chk("t3_nwr", obs_q.size(), 0);
    start_pulse();
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
    chk("t3_restart_addr", (obs_q.size() == 1) ? {18'b0, obs_q[0].a} : 32'hFFFF_FFFF, 0);
    wait_end();
    obs_q.delete();

    // 4: no timeout before first byte; glitch and framing error.
    start_pulse();
    repeat (500) @(negedge clk);
    chk("t4_wait_forever", loading, 1);
    send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 1);
    glitch();
    chk("t4_glitch_ferr", frame_err, 0);
    send_byte(8'h55, 0);
    chk("t4_bad_stop_ferr", frame_err, 1);
    send_byte(8'($urandom), 1);
    send_byte(8'($urandom), 1);
    chk("t4_nwr", obs_q.size(), 1);
    wait_end();
    obs_q.delete();

    // 5: reset in the middle of the second word.
    start_pulse();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
    rx = 1'b0;
    repeat (40) @(negedge clk);
    rst_n = 1'b0;
    m_load = 0; m_got = 0; m_fe = 0; m_bytes = 0; m_words = 0;
    m_last_a = '0; m_last_d = '0; exp_done_next = 0;
    exp_q.delete();
    #1;
    chk("t5_loading", loading, 0);
    chk("t5_done", done, 0);
    chk("t5_wren", wr_en, 0);
    chk("t5_addr", wr_addr, 0);
    chk("t5_data", wr_data, 0);
    chk("t5_ferr", frame_err, 0);
    chk("t5_tx", tx, 1);
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("t5_idle_loading", loading, 0);
    chk("t5_idle_done", done, 0);
    obs_q.delete();

    // 6: echo of 0xA5 (or a quiet TX line when echo is not built).
    start_pulse();
`ifdef UART_COE_LOADER_ECHO_EN
    fork
      send_byte(8'hA5, 1);
      begin
        logic [7:0] eb;
        int t = 0;
        eb = 8'hA5;
        while (tx && t < 400) begin
          @(negedge clk);
          t++;
        end
        chk("t6_echo_start_lo", t >= 150, 1);
        chk("t6_echo_start_hi", t <= 162, 1);
        repeat (8) @(negedge clk);
        chk("t6_echo_startbit", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          chk("t6_echo_bit", tx, eb[i]);
        end
        repeat (16) @(negedge clk);
        chk("t6_echo_stop", tx, 1);
      end
    join
`else
    send_byte(8'hA5, 1);
    chk("t6_tx_quiet", tx, 1);
`endif
    wait_end();
    obs_q.delete();

    // Random loads with random gaps and occasional glitches.
    for (int it = 0; it < 3; it++) begin
      int nb;
      start_pulse();
      nb = $urandom_range(1, 20);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 7) == 0) glitch();
        send_byte(8'($urandom), 1);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_end();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
